// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared widths and entry type for the MCU fetch path
package mcu_pkg;

    localparam int MCU_XLEN = 32;

    typedef struct packed {
        logic [MCU_XLEN-1:0] pc;
        logic [MCU_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/mcu_fifo.sv
// rtl/mcu_fifo.sv - generic synchronous FIFO with clear and occupancy count
module mcu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; readers qualify the head with count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) (push && full) |-> (pop || clear));

endmodule

// File: rtl/mcu_fetch_buffer.sv
// rtl/mcu_fetch_buffer.sv - fetch response queue with in-flight tracker, credit stall and flush
module mcu_fetch_buffer
    import mcu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int IMEM_LAT = 1,
    parameter int XLEN     = MCU_XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_req,
    input  logic [XLEN-1:0]         fetch_pc,
    input  logic [XLEN-1:0]         imem_rdata,
    input  logic                    flush,
    output logic                    fetch_stall,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [XLEN-1:0]         dec_pc,
    output logic [XLEN-1:0]         dec_instr,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [IMEM_LAT-1:0] infl_valid;
    logic [XLEN-1:0]     infl_pc [IMEM_LAT];
    logic [CW-1:0]       infl_count;
    logic [CW-1:0]       count;
    logic                issue;
    logic                push;
    logic                pop;
    logic                empty;
    logic [2*XLEN-1:0]   head;

    assign issue = fetch_req & ~fetch_stall & ~flush;
    assign push  = infl_valid[IMEM_LAT-1] & ~flush;
    assign pop   = dec_valid & dec_ready;

    // Each stage remembers which PC the IMEM is currently working on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_valid <= '0;
            for (int i = 0; i < IMEM_LAT; i++) infl_pc[i] <= '0;
        end else begin
            infl_valid[0] <= issue;
            infl_pc[0]    <= fetch_pc;
            for (int i = 1; i < IMEM_LAT; i++) begin
                infl_valid[i] <= infl_valid[i-1] & ~flush;
                infl_pc[i]    <= infl_pc[i-1];
            end
        end
    end

    always_comb begin
        infl_count = '0;
        for (int i = 0; i < IMEM_LAT; i++) infl_count = infl_count + CW'(infl_valid[i]);
    end

    // Requests already in flight hold a queue slot, so the stall never needs dec_ready.
    assign fetch_stall = ({1'b0, count} + {1'b0, infl_count}) >= (CW + 1)'(DEPTH);

    mcu_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data ({infl_pc[IMEM_LAT-1], imem_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty)
    );

    assign dec_valid = ~empty;
    assign dec_pc    = dec_valid ? head[2*XLEN-1:XLEN] : '0;
    assign dec_instr = dec_valid ? head[XLEN-1:0]      : '0;
    assign occupancy = count;

    a_credit: assert property (@(posedge clk) disable iff (!rst_n) push |-> ((count != CW'(DEPTH)) || pop));

endmodule

// File: tb/tb_mcu_fetch_buffer.sv
// tb/tb_mcu_fetch_buffer.sv - scoreboard bench for mcu_fetch_buffer at IMEM_LAT 1 and 2
module tb_mcu_fetch_buffer;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req   [2];
    logic        flush       [2];
    logic        dec_ready   [2];
    logic [31:0] fetch_pc    [2];
    logic [31:0] imem_rdata  [2];
    logic        fetch_stall [2];
    logic        dec_valid   [2];
    logic [31:0] dec_pc      [2];
    logic [31:0] dec_instr   [2];
    logic [2:0]  occupancy   [2];

    logic [31:0] d0_pc, d1_pc_a, d1_pc_b;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] mon_e;
    logic [31:0] pc;
    int          n;
    int          checks = 0;
    int          errors = 0;
    bit          acc;

    always #5 clk = ~clk;

    mcu_fetch_buffer #(.DEPTH(4), .IMEM_LAT(1), .XLEN(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req[0]), .fetch_pc(fetch_pc[0]),
        .imem_rdata(imem_rdata[0]), .flush(flush[0]), .fetch_stall(fetch_stall[0]),
        .dec_valid(dec_valid[0]), .dec_ready(dec_ready[0]), .dec_pc(dec_pc[0]),
        .dec_instr(dec_instr[0]), .occupancy(occupancy[0])
    );

    mcu_fetch_buffer #(.DEPTH(4), .IMEM_LAT(2), .XLEN(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req[1]), .fetch_pc(fetch_pc[1]),
        .imem_rdata(imem_rdata[1]), .flush(flush[1]), .fetch_stall(fetch_stall[1]),
        .dec_valid(dec_valid[1]), .dec_ready(dec_ready[1]), .dec_pc(dec_pc[1]),
        .dec_instr(dec_instr[1]), .occupancy(occupancy[1])
    );

    // IMEM model: returns pc ^ KEY for the PC presented IMEM_LAT cycles earlier.
    always @(posedge clk) begin
        d0_pc   <= fetch_pc[0];
        d1_pc_a <= fetch_pc[1];
        d1_pc_b <= d1_pc_a;
    end
    assign imem_rdata[0] = d0_pc ^ KEY;
    assign imem_rdata[1] = d1_pc_b ^ KEY;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic step(input int d, input bit req, input logic [31:0] p, input bit fl, input bit rdy);
        fetch_req[d] = req;
        fetch_pc[d]  = p;
        flush[d]     = fl;
        dec_ready[d] = rdy;
        acc = req && !fetch_stall[d] && !fl;
        if (acc) begin
            if (d == 0) exp0.push_back(p);
            else        exp1.push_back(p);
        end
        @(posedge clk);
        if (fl) begin
            if (d == 0) exp0.delete();
            else        exp1.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("occupancy_bound_dut%0d", d), 32'(occupancy[d] <= 3'd4), 32'd1);
                if (dec_valid[d] && dec_ready[d]) begin
                    if (qsize(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_entry_dut%0d actual pc=0x%08h required=no entry", d, dec_pc[d]);
                    end else begin
                        if (d == 0) mon_e = exp0.pop_front();
                        else        mon_e = exp1.pop_front();
                        chk($sformatf("dec_pc_dut%0d", d), dec_pc[d], mon_e);
                        chk($sformatf("dec_instr_dut%0d", d), dec_instr[d], mon_e ^ KEY);
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            fetch_req[d] = 1'b0; fetch_pc[d] = '0; flush[d] = 1'b0; dec_ready[d] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_dec_valid", 32'(dec_valid[d]), 0);
            chk("reset_fetch_stall", 32'(fetch_stall[d]), 0);
            chk("reset_occupancy", 32'(occupancy[d]), 0);
            chk("reset_dec_pc", dec_pc[d], 0);
            chk("reset_dec_instr", dec_instr[d], 0);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // streaming, IMEM_LAT=1, decode always ready
        for (int i = 0; i < 8; i++) begin
            chk("stream_stall", 32'(fetch_stall[0]), 0);
            step(0, 1'b1, 32'(i * 4), 1'b0, 1'b1);
            if (i == 0) chk("stream_latency_early", 32'(dec_valid[0]), 0);
            if (i == 1) begin
                chk("stream_first_valid", 32'(dec_valid[0]), 1);
                chk("stream_first_pc", dec_pc[0], 32'h0);
                chk("stream_first_instr", dec_instr[0], KEY);
            end
        end
        repeat (3) step(0, 1'b0, '0, 1'b0, 1'b1);
        chk("stream_drained", 32'(qsize(0)), 0);
        chk("stream_occ_empty", 32'(occupancy[0]), 0);

        // back-pressure: decode stalled
        pc = 32'h40;
        for (int i = 0; i < 8; i++) begin
            chk("bp_stall", 32'(fetch_stall[0]), 32'(i >= 4));
            step(0, 1'b1, pc, 1'b0, 1'b0);
            if (acc) pc += 32'd4;
        end
        chk("bp_occ_full", 32'(occupancy[0]), 4);
        chk("bp_head_pc", dec_pc[0], 32'h40);
        step(0, 1'b0, '0, 1'b0, 1'b1);
        chk("bp_stall_release", 32'(fetch_stall[0]), 0);
        chk("bp_occ_after_pop", 32'(occupancy[0]), 3);
        repeat (4) step(0, 1'b0, '0, 1'b0, 1'b1);
        chk("bp_drained", 32'(qsize(0)), 0);

        // flush while 0x100 is in flight
        step(0, 1'b1, 32'h100, 1'b0, 1'b1);
        step(0, 1'b0, '0, 1'b1, 1'b1);
        chk("flush_dec_valid", 32'(dec_valid[0]), 0);
        chk("flush_stall", 32'(fetch_stall[0]), 0);
        step(0, 1'b1, 32'h200, 1'b0, 1'b0);
        step(0, 1'b0, '0, 1'b0, 1'b0);
        chk("flush_next_valid", 32'(dec_valid[0]), 1);
        chk("flush_next_pc", dec_pc[0], 32'h200);
        step(0, 1'b0, '0, 1'b0, 1'b1);
        chk("flush_drained", 32'(qsize(0)), 0);

        // flush of a full queue with a simultaneous pop, then wrap
        pc = 32'h300;
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, pc, 1'b0, 1'b0);
            if (acc) pc += 32'd4;
        end
        chk("ffull_occ", 32'(occupancy[0]), 4);
        step(0, 1'b0, '0, 1'b1, 1'b1);
        chk("ffull_occ_zero", 32'(occupancy[0]), 0);
        chk("ffull_dec_valid", 32'(dec_valid[0]), 0);
        chk("ffull_stall", 32'(fetch_stall[0]), 0);
        pc = 32'h400;
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, pc, 1'b0, 1'b1);
            if (acc) pc += 32'd4;
        end
        repeat (4) step(0, 1'b0, '0, 1'b0, 1'b1);
        chk("ffull_wrap_drained", 32'(qsize(0)), 0);

        // asynchronous reset mid-operation
        step(0, 1'b1, 32'h500, 1'b0, 1'b0);
        step(0, 1'b1, 32'h504, 1'b0, 1'b0);
        step(0, 1'b1, 32'h508, 1'b0, 1'b0);
        step(0, 1'b1, 32'h50C, 1'b0, 1'b0);
        chk("rst_pre_occ", 32'(occupancy[0]), 3);
        chk("rst_pre_stall", 32'(fetch_stall[0]), 1);
        fetch_req[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_dec_valid", 32'(dec_valid[0]), 0);
        chk("rst_async_stall", 32'(fetch_stall[0]), 0);
        chk("rst_async_occ", 32'(occupancy[0]), 0);
        chk("rst_async_dec_pc", dec_pc[0], 0);
        exp0.delete();
        rst_n = 1'b1;
        step(0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_post_dec_valid", 32'(dec_valid[0]), 0);

        // IMEM_LAT=2 wrap-around with random decode readiness
        pc = 32'h1000;
        n  = 0;
        for (int c = 0; c < 300 && n < 12; c++) begin
            step(1, 1'b1, pc, 1'b0, 1'($urandom_range(0, 1)));
            if (acc) begin
                pc += 32'd4;
                n++;
            end
        end
        chk("wrap_accepts", 32'(n), 12);
        repeat (12) step(1, 1'b0, '0, 1'b0, 1'b1);
        chk("wrap_drained", 32'(qsize(1)), 0);
        chk("wrap_occ_empty", 32'(occupancy[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_fetch_buffer.md
Name: mcu_fetch_buffer

Overview:
- Downstream neighbour of the MCU instruction-fetch stage: captures instruction-memory read data returned for each issued PC and queues {pc, instr} pairs for the decode stage.
- Absorbs fixed IMEM read latency, decouples decode back-pressure from fetch via a credit-based stall, and squashes in-flight and queued fetches on a pipeline flush (branch/trap redirect).

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- IMEM_LAT, 1, cycles from fetch_req to imem_rdata valid; legal 1..2
- XLEN, 32, PC/instruction width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch stage issued a read for fetch_pc this cycle
- fetch_pc  in  XLEN  PC presented to IMEM this cycle
- imem_rdata  in  XLEN  IMEM read data, valid IMEM_LAT cycles after its fetch_req
- flush  in  1  redirect; kill everything queued or in flight
- fetch_stall  out  1  back-pressure to fetch stage (hold PC, no new request)
- dec_valid  out  1  head entry valid for decode
- dec_ready  in  1  decode accepts head this cycle
- dec_pc  out  XLEN  head PC
- dec_instr  out  XLEN  head instruction
- occupancy  out  $clog2(DEPTH)+1  queued entries (debug/perf)

Behaviour:
- Reset (async, rst_n low): count=0, rd/wr pointers=0, in-flight valid bits=0; dec_valid=0, fetch_stall=0, occupancy=0, dec_pc=0, dec_instr=0. Takes effect immediately, mid-operation included.
- In-flight tracker: IMEM_LAT-stage shift register of {valid, pc}; stage 0 loads {fetch_req & ~fetch_stall & ~flush, fetch_pc}. Response arrives when the last stage is valid; that cycle imem_rdata pairs with that stage's pc.
- Enqueue: on response arrival (and no flush), {pc, imem_rdata} written at wr_ptr; wr_ptr increments mod DEPTH.
- Dequeue: dec_valid = (count != 0); head driven from rd_ptr; dec_pc/dec_instr forced to 0 when dec_valid=0. Handshake dec_valid & dec_ready pops head, rd_ptr increments mod DEPTH.
- Simultaneous enqueue + dequeue: count unchanged; legal at any occupancy including full.
- Latency: fetch_req at cycle t -> dec_valid with that entry at t+IMEM_LAT+1 (queue empty case). Strict program order preserved.
- Credit stall: fetch_stall = (count + inflight_count) >= DEPTH, from registered state only (no dec_ready path). Guarantees no overflow. fetch_req while fetch_stall=1 is ignored (not tracked).
- Flush (dominates all): at the edge, count=0, pointers reset to 0, all in-flight valid bits cleared; the response arriving in the flush cycle is dropped; fetch_req in the flush cycle is ignored; a dequeue handshake in that cycle is still considered consumed by decode. Next cycle dec_valid=0, fetch_stall=0.
- Full/empty: enqueue at count==DEPTH and dequeue at count==0 are unreachable; covered by assertions.
- occupancy = count (registered).

Decomposition:
- mcu_pkg: XLEN constant, fetch_entry_t struct {pc, instr}.
- One sub-module: mcu_fifo (generic sync FIFO: width/depth params, push/pop, clear, count, async active-low reset). Top block holds the in-flight tracker, credit stall and flush glue.

Test Plan:
- Reset: drive 3 entries in, then pulse rst_n low between edges -> dec_valid, fetch_stall, occupancy read 0 at once, without waiting for a clock edge.
- Streaming, IMEM_LAT=1, dec_ready=1: fetch_req every cycle with pc 0x0,0x4,0x8,...; imem_rdata = pc^0xA5A5A5A5 -> first dec_valid at cycle 2 with pc 0x0/instr 0xA5A5A5A5, then one per cycle in order, fetch_stall never asserts.
- Back-pressure, DEPTH=4, dec_ready=0: continuous fetch_req -> fetch_stall rises once count+inflight=4, occupancy settles at 4, no entry lost; raise dec_ready -> pcs drain in order, stall drops after first pop.
- Flush with in-flight: fetch_req pc 0x100, flush asserted the cycle its response arrives -> 0x100 never reaches dec_valid; subsequent fetch_req pc 0x200 delivered as next head.
- Flush with full queue plus simultaneous pop: occupancy 4, dec_ready=1, flush=1 -> next cycle occupancy 0, dec_valid 0, pointers restart cleanly (later entries emerge correctly across wrap).
- Wrap-around, IMEM_LAT=2: 3*DEPTH fetches with random dec_ready -> scoreboard sees every pc exactly once in order; fetch_stall never lets count exceed DEPTH.
